// File: rtl/pe_pkg.sv
// Shared types and default sizes for the MAC/accumulate processing element.
// Imported by the requantizer and the top-level PE.
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_RESULT = 2'd2
    } pe_state_e;

    localparam int DW_DEF   = 8;
    localparam int ACCW_DEF = 24;
    localparam int OW_DEF   = 8;
    localparam int LENW_DEF = 8;
    localparam int SHW      = 5;

endpackage

// File: rtl/pe_requant.sv
// Combinational requantizer: right shift of the accumulator, then clamp
// to the signed or unsigned OW-bit range with an overflow flag.
module pe_requant
    import pe_pkg::*;
#(
    parameter int ACCW = ACCW_DEF,
    parameter int OW   = OW_DEF
) (
    input  logic [ACCW-1:0] acc,
    input  logic [SHW-1:0]  shift,
    input  logic            signed_mode,
    output logic [OW-1:0]   res,
    output logic            res_ovf
);

    logic [ACCW-1:0] sh;
    logic [ACCW-OW:0] top;

    // shift, then saturate when the upper bits do not fit the output range
    always_comb begin
        if (signed_mode) begin
            sh = $signed(acc) >>> shift;
        end else begin
            sh = acc >> shift;
        end
        top     = sh[ACCW-1:OW-1];
        res     = sh[OW-1:0];
        res_ovf = 1'b0;
        if (signed_mode) begin
            if (!(&top) && (|top)) begin
                res_ovf = 1'b1;
                res     = sh[ACCW-1] ? {1'b1, {(OW-1){1'b0}}}
                                     : {1'b0, {(OW-1){1'b1}}};
            end
        end else begin
            if (|sh[ACCW-1:OW]) begin
                res_ovf = 1'b1;
                res     = '1;
            end
        end
    end

endmodule

// File: rtl/pe_mac_acc.sv
// Systolic MAC processing element: accumulates len products per tile,
// then presents a requantized result under a valid/ready handshake.
module pe_mac_acc
    import pe_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF,
    parameter int OW   = OW_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LENW-1:0] len,
    input  logic            signed_mode,
    input  logic [SHW-1:0]  shift,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_a,
    input  logic [DW-1:0]   in_b,
    output logic            out_valid,
    output logic [DW-1:0]   out_a,
    output logic [DW-1:0]   out_b,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [OW-1:0]   res,
    output logic            res_ovf
);

    pe_state_e state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic [LENW-1:0] len_q, len_d;
    logic            sgn_q, sgn_d;
    logic [SHW-1:0]  shift_q, shift_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_a_q, out_a_d;
    logic [DW-1:0]   out_b_q, out_b_d;

    logic signed [2*DW-1:0] sprod;
    logic [2*DW-1:0]        uprod;
    logic [ACCW-1:0]        prod;
    logic [OW-1:0]          rq_res;
    logic                   rq_ovf;

    // product of the current operands, extended per the latched mode
    always_comb begin
        sprod = $signed(in_a) * $signed(in_b);
        uprod = in_a * in_b;
        if (sgn_q) begin
            prod = ACCW'(sprod);
        end else begin
            prod = ACCW'(uprod);
        end
    end

    // tile control: latch config on start, accumulate beats, hand off result
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sgn_d   = sgn_q;
        shift_d = shift_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len;
                    sgn_d   = signed_mode;
                    shift_d = shift;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (len == '0) ? ST_RESULT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = acc_q + prod;
                    cnt_d = cnt_q + LENW'(1);
                    if (cnt_d == len_q) begin
                        state_d = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // systolic pass-through, independent of the FSM
    always_comb begin
        out_valid_d = in_valid;
        out_a_d     = in_a;
        out_b_d     = in_b;
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            sgn_q       <= 1'b0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sgn_q       <= sgn_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    pe_requant #(
        .ACCW (ACCW),
        .OW   (OW)
    ) u_requant (
        .acc         (acc_q),
        .shift       (shift_q),
        .signed_mode (sgn_q),
        .res         (rq_res),
        .res_ovf     (rq_ovf)
    );

    // result is only driven while it is being offered
    always_comb begin
        busy      = (state_q != ST_IDLE);
        res_valid = (state_q == ST_RESULT);
        res       = res_valid ? rq_res : '0;
        res_ovf   = res_valid & rq_ovf;
        out_valid = out_valid_q;
        out_a     = out_a_q;
        out_b     = out_b_q;
    end

endmodule

// File: tb/tb_pe_mac_acc.sv
// Scoreboard bench for pe_mac_acc: directed tiles push expected results,
// a negedge monitor pops and compares whenever res_valid is offered.
module tb_pe_mac_acc;

    typedef logic [7:0] v5_t [5];
    typedef struct packed {
        logic [7:0] r;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] len = '0;
    logic       signed_mode = 1'b0;
    logic [4:0] shift = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       out_valid;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       busy;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res;
    logic       res_ovf;

    int   total = 0;
    int   passed = 0;
    exp_t q[$];
    exp_t cur = '0;
    bit   got = 1'b0;

    pe_mac_acc dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .signed_mode (signed_mode),
        .shift       (shift),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_a       (out_a),
        .out_b       (out_b),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res         (res),
        .res_ovf     (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // monitor: first valid cycle pops, later valid cycles check stability
    always @(negedge clk) begin
        if (rst && res_valid) begin
            if (!got) begin
                got = 1'b1;
                chk("sb_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    chk("res", res, cur.r);
                    chk("res_ovf", res_ovf, cur.o);
                end
            end else begin
                chk("res_hold", res, cur.r);
                chk("ovf_hold", res_ovf, cur.o);
            end
        end else begin
            got = 1'b0;
        end
    end

    task automatic tile(input logic [7:0] n, input logic sg,
                        input logic [4:0] sh, input v5_t a, input v5_t b,
                        input logic [4:0] vp, input int nb,
                        input logic [7:0] er, input logic eo);
        int k;
        k = 0;
        q.push_back({er, eo});
        start = 1'b1;
        len = n;
        signed_mode = sg;
        shift = sh;
        in_valid = 1'b1;
        in_a = 8'h7f;
        in_b = 8'h7f;
        cyc();
        start = 1'b0;
        in_valid = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < nb; i++) begin
            in_valid = vp[i];
            in_a = a[k];
            in_b = b[k];
            if (vp[i]) k++;
            cyc();
        end
        in_valid = 1'b0;
        chk("res_valid_latency", res_valid, 1);
        cyc();
        chk("idle_after_ack", res_valid, 0);
        chk("busy_after_ack", busy, 0);
    endtask

    task automatic pt_chk(input string nm);
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_out_a"}, out_a, 8'h5a);
        chk({nm, "_out_b"}, out_b, 8'ha5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b1;
        in_a = 8'h5a;
        in_b = 8'ha5;
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_res_ovf", res_ovf, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();

        tile(3, 0, 0, '{8'd2, 8'd3, 8'd4, 8'd0, 8'd0},
             '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0}, 5'b00111, 3, 8'd56, 0);
        tile(2, 1, 0, '{8'hfd, 8'h04, 8'd0, 8'd0, 8'd0},
             '{8'h05, 8'hfa, 8'd0, 8'd0, 8'd0}, 5'b00011, 2, 8'hd9, 0);
        tile(2, 0, 0, '{8'hff, 8'hff, 8'd0, 8'd0, 8'd0},
             '{8'hff, 8'hff, 8'd0, 8'd0, 8'd0}, 5'b00011, 2, 8'hff, 1);
        tile(2, 0, 10, '{8'hff, 8'hff, 8'd0, 8'd0, 8'd0},
             '{8'hff, 8'hff, 8'd0, 8'd0, 8'd0}, 5'b00011, 2, 8'd127, 0);
        tile(1, 1, 0, '{8'h80, 8'd0, 8'd0, 8'd0, 8'd0},
             '{8'h7f, 8'd0, 8'd0, 8'd0, 8'd0}, 5'b00001, 1, 8'h80, 1);
        tile(1, 1, 7, '{8'h80, 8'd0, 8'd0, 8'd0, 8'd0},
             '{8'h7f, 8'd0, 8'd0, 8'd0, 8'd0}, 5'b00001, 1, 8'h81, 0);
        tile(3, 0, 0, '{8'd2, 8'd3, 8'd4, 8'd0, 8'd0},
             '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0}, 5'b11001, 5, 8'd56, 0);

        // len=0 with downstream stalled and start pulses
        res_ready = 1'b0;
        q.push_back({8'h00, 1'b0});
        start = 1'b1;
        len = 8'd0;
        cyc();
        chk("len0_res_valid", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len = 8'd3;
            in_valid = 1'b1;
            cyc();
            chk("stall_res_valid", res_valid, 1);
            chk("stall_busy", busy, 1);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        cyc();
        start = 1'b0;
        chk("exit_res_valid", res_valid, 0);
        chk("exit_start_ignored", busy, 0);
        cyc();
        chk("still_idle", busy, 0);

        // pass-through in IDLE, ACC and RESULT
        in_valid = 1'b1;
        in_a = 8'h5a;
        in_b = 8'ha5;
        cyc();
        pt_chk("pt_idle");
        chk("pt_idle_busy", busy, 0);
        q.push_back({8'hff, 1'b1});
        start = 1'b1;
        len = 8'd1;
        signed_mode = 1'b0;
        shift = 5'd0;
        in_valid = 1'b0;
        cyc();
        start = 1'b0;
        chk("pt_gap_out_valid", out_valid, 0);
        in_valid = 1'b1;
        cyc();
        pt_chk("pt_acc");
        res_ready = 1'b0;
        cyc();
        pt_chk("pt_result");
        chk("pt_result_valid", res_valid, 1);
        in_valid = 1'b0;
        res_ready = 1'b1;
        cyc();
        chk("pt_exit_valid", res_valid, 0);

        // asynchronous reset in the middle of a tile
        start = 1'b1;
        len = 8'd3;
        signed_mode = 1'b0;
        shift = 5'd0;
        cyc();
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 8'd2;
        in_b = 8'd5;
        cyc();
        chk("mid_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_a", out_a, 0);
        chk("arst_res", res, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        tile(3, 0, 0, '{8'd2, 8'd3, 8'd4, 8'd0, 8'd0},
             '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0}, 5'b00111, 3, 8'd56, 0);

        cyc();
        chk("sb_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
